// File: rtl/axi_llc_pkg.sv
// Shared types and constants for the LLC data ways.
package axi_llc_pkg;

  // Deepest read pipeline a data SRAM macro may have.
  localparam int unsigned MaxDataMacroLatency = 4;

  typedef enum logic [1:0] {
    EvictUnit = 2'd0,
    RefilUnit = 2'd1,
    ReadUnit  = 2'd2,
    WriteUnit = 2'd3
  } cache_unit_e;

  typedef struct packed {
    int unsigned IndexLength;
    int unsigned BlockOffsetLength;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned BlockSize;
  } llc_cfg_t;

  localparam int unsigned DefIndexLength       = 4;
  localparam int unsigned DefBlockOffsetLength = 2;
  localparam int unsigned DefBlockSize         = 64;
  localparam int unsigned DefNumWays           = 8;

  localparam llc_cfg_t DefaultCfg = '{
    IndexLength:       DefIndexLength,
    BlockOffsetLength: DefBlockOffsetLength,
    NumLines:          2 ** DefIndexLength,
    NumBlocks:         2 ** DefBlockOffsetLength,
    BlockSize:         DefBlockSize
  };

  typedef struct packed {
    cache_unit_e                     cache_unit;
    logic [DefNumWays-1:0]           way_ind;
    logic [DefIndexLength-1:0]       line_addr;
    logic [DefBlockOffsetLength-1:0] blk_offset;
    logic                            we;
    logic [DefBlockSize-1:0]         data;
    logic [DefBlockSize/8-1:0]       strb;
  } way_inp_t;

  typedef struct packed {
    cache_unit_e             cache_unit;
    logic [DefBlockSize-1:0] data;
  } way_oup_t;

  // Counter width able to hold every value from 0 up to and including depth.
  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axi_llc_data_way_obuf.sv
// Fall-through FIFO holding read results until the read-data mux takes them.
module axi_llc_data_way_obuf #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output logic   valid_o,
  output entry_t data_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  entry_t              mem_q [Depth];
  entry_t              mem_d [Depth];
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                empty, full, store, take;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    if (p == PtrWidth'(Depth - 1)) return '0;
    return p + PtrWidth'(1);
  endfunction

  // An empty buffer forwards a push straight to the output; a push consumed that way is never stored.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CntWidth'(Depth));
    valid_o = ~empty | push_i;
    data_o  = '0;
    if (!empty)      data_o = mem_q[rd_ptr_q];
    else if (push_i) data_o = data_i;
    store   = push_i & ~(empty & pop_i);
    take    = pop_i & ~empty;
  end

  // Pointer, occupancy and storage updates.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (store) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (take) rd_ptr_d = next_ptr(rd_ptr_q);
    if (store && !take)      count_d = count_q + CntWidth'(1);
    else if (take && !store) count_d = count_q - CntWidth'(1);
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // A push into a full buffer is only safe when the head leaves in the same cycle.
  assert property (@(posedge clk_i) disable iff (rst_i) (push_i && full) |-> pop_i);

endmodule

// File: rtl/axi_llc_sram_data.sv
// Behavioural single-port data SRAM macro with byte enables and a configurable read latency.
module axi_llc_sram_data #(
  parameter int unsigned Latency   = 1,
  parameter int unsigned NumWords  = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                   clk_i,
  input  logic                   test_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] be_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] rdata_q [Latency];
  logic [DataWidth-1:0] rdata_d [Latency];
  logic [DataWidth-1:0] wr_word;
  logic                 unused_test;

  assign unused_test = test_i;
  assign rdata_o     = rdata_q[Latency-1];

  // Merge enabled bytes of the write data into the addressed word.
  always_comb begin
    wr_word = mem_q[addr_i];
    for (int unsigned b = 0; b < DataWidth / 8; b++) begin
      if (be_i[b]) wr_word[8*b +: 8] = wdata_i[8*b +: 8];
    end
  end

  // Read data enters the first stage and walks down the latency pipe.
  always_comb begin
    rdata_d = rdata_q;
    if (req_i && !we_i) rdata_d[0] = mem_q[addr_i];
    for (int unsigned i = 1; i < Latency; i++) rdata_d[i] = rdata_q[i-1];
  end

  // Array contents and read pipe are not reset, as in a real macro.
  always_ff @(posedge clk_i) begin
    if (req_i && we_i) mem_q[addr_i] <= wr_word;
    rdata_q <= rdata_d;
  end

endmodule

// File: rtl/axi_llc_data_way_pipe.sv
// One cache way's data storage: drives the data macro and returns read data tagged with its cache unit.
module axi_llc_data_way_pipe #(
  parameter axi_llc_pkg::llc_cfg_t Cfg          = axi_llc_pkg::DefaultCfg,
  parameter type                   way_inp_t    = axi_llc_pkg::way_inp_t,
  parameter type                   way_oup_t    = axi_llc_pkg::way_oup_t,
  parameter int unsigned           MacroLatency = 1,
  parameter int unsigned           OutBufDepth  = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     test_i,
  input  way_inp_t inp_i,
  input  logic     inp_valid_i,
  output logic     inp_ready_o,
  output way_oup_t out_o,
  output logic     out_valid_o,
  input  logic     out_ready_i
);

  import axi_llc_pkg::*;

  localparam int unsigned AddrWidth = Cfg.IndexLength + Cfg.BlockOffsetLength;
  localparam int unsigned NumWords  = Cfg.NumLines * Cfg.NumBlocks;
  localparam int unsigned DataWidth = Cfg.BlockSize;
  localparam int unsigned CntWidth  = credit_width(OutBufDepth);

  if (MacroLatency < 1 || MacroLatency > MaxDataMacroLatency) begin : gen_bad_latency
    $fatal(1, "axi_llc_data_way_pipe: MacroLatency %0d outside 1..%0d", MacroLatency, MaxDataMacroLatency);
  end
  if (OutBufDepth == 0) begin : gen_bad_depth
    $fatal(1, "axi_llc_data_way_pipe: OutBufDepth must be at least 1");
  end

  logic                    read_req, read_acc, macro_req, pop, buf_valid;
  logic [CntWidth-1:0]     credit_q, credit_d;
  logic [MacroLatency-1:0] meta_valid_q, meta_valid_d;
  cache_unit_e             meta_unit_q [MacroLatency];
  cache_unit_e             meta_unit_d [MacroLatency];
  logic [DataWidth-1:0]    rdata;
  way_oup_t                push_data;
  logic                    unused_way_ind;

  assign out_valid_o    = buf_valid;
  assign unused_way_ind = ^inp_i.way_ind;

  // Writes always pass; a read needs a free credit or the slot freed by this cycle's output handshake.
  always_comb begin
    pop         = buf_valid & out_ready_i;
    read_req    = inp_valid_i & ~inp_i.we;
    inp_ready_o = inp_i.we | (credit_q != '0) | pop;
    read_acc    = read_req & inp_ready_o;
    macro_req   = inp_valid_i & inp_ready_o;
  end

  // Credits count buffer slots not yet claimed by reads travelling through the macro.
  always_comb begin
    credit_d = credit_q;
    if (read_acc && !pop)      credit_d = credit_q - CntWidth'(1);
    else if (pop && !read_acc) credit_d = credit_q + CntWidth'(1);
  end

  // Routing tag travels alongside the macro read so it lands together with the data.
  always_comb begin
    meta_valid_d    = '0;
    meta_unit_d     = meta_unit_q;
    meta_valid_d[0] = read_acc;
    meta_unit_d[0]  = inp_i.cache_unit;
    for (int unsigned i = 1; i < MacroLatency; i++) begin
      meta_valid_d[i] = meta_valid_q[i-1];
      meta_unit_d[i]  = meta_unit_q[i-1];
    end
  end

  // Reset drops every in-flight read and restores the full credit pool.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_q     <= CntWidth'(OutBufDepth);
      meta_valid_q <= '0;
      for (int unsigned i = 0; i < MacroLatency; i++) meta_unit_q[i] <= EvictUnit;
    end else begin
      credit_q     <= credit_d;
      meta_valid_q <= meta_valid_d;
      meta_unit_q  <= meta_unit_d;
    end
  end

  // Pack the arriving macro data with its routing tag.
  always_comb begin
    push_data            = '0;
    push_data.cache_unit = meta_unit_q[MacroLatency-1];
    push_data.data       = rdata;
  end

  axi_llc_sram_data #(
    .Latency   (MacroLatency),
    .NumWords  (NumWords),
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) i_macro (
    .clk_i   (clk_i),
    .test_i  (test_i),
    .req_i   (macro_req),
    .we_i    (inp_i.we),
    .addr_i  ({inp_i.line_addr, inp_i.blk_offset}),
    .wdata_i (inp_i.data),
    .be_i    (inp_i.strb),
    .rdata_o (rdata)
  );

  axi_llc_data_way_obuf #(
    .Depth   (OutBufDepth),
    .entry_t (way_oup_t)
  ) i_obuf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (meta_valid_q[MacroLatency-1]),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (buf_valid),
    .data_o  (out_o)
  );

  // Credit pool never exceeds the buffer and never goes negative.
  assert property (@(posedge clk_i) disable iff (rst_i) credit_q <= CntWidth'(OutBufDepth));
  assert property (@(posedge clk_i) disable iff (rst_i) (read_acc && !pop) |-> (credit_q != '0));

endmodule
